// File: rtl/serial_word_collector.sv
// Packs the serial adder's LSB-first result bits into words, tags each word with the
// overflow flag reported at the start of the following frame, and queues them for a consumer.
module serial_word_collector #(
  parameter int WORD_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              EN,
  input  logic              SER_IN,
  input  logic              OVF_IN,
  output logic [WORD_W-1:0] WORD_OUT,
  output logic              WORD_OVF,
  output logic              WORD_VALID,
  input  logic              WORD_READY,
  output logic [7:0]        DROP_CNT,
  output logic [7:0]        OVF_CNT
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_FIRST   = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0]        state_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_next;
  logic [WORD_W-1:0] pend_word_reg;
  logic              pend_valid_reg;

  // Each entry is {word, overflow tag}.
  logic [WORD_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [7:0]        drop_cnt_reg;
  logic [7:0]        ovf_cnt_reg;

  logic              last_bit;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              accept;
  logic              drop;
  logic [WORD_W:0]   head;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_shift
      assign shift_next[gi] = (bit_idx_reg == IDX_W'(gi)) ? SER_IN : shift_reg[gi];
    end
  endgenerate

  assign last_bit  = (bit_idx_reg == IDX_W'(WORD_W - 1));
  // The overflow for a finished word only arrives with bit 0 of the next frame.
  assign push      = EN && (bit_idx_reg == '0) && pend_valid_reg && (state_reg == ST_COLLECT);
  assign fifo_full = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop       = WORD_VALID && WORD_READY;
  assign accept    = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  assign head       = mem[rd_ptr_reg];
  assign WORD_VALID = (count_reg != '0);
  assign WORD_OUT   = WORD_VALID ? head[WORD_W:1] : '0;
  assign WORD_OVF   = WORD_VALID & head[0];
  assign DROP_CNT   = drop_cnt_reg;
  assign OVF_CNT    = ovf_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      mem[wr_ptr_reg] <= {pend_word_reg, OVF_IN};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= ST_FIRST;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      pend_word_reg  <= '0;
      pend_valid_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_cnt_reg   <= '0;
      ovf_cnt_reg    <= '0;
    end else begin
      if (EN) begin
        shift_reg   <= shift_next;
        bit_idx_reg <= last_bit ? '0 : bit_idx_reg + IDX_W'(1);
        if (last_bit) begin
          pend_word_reg  <= shift_next;
          pend_valid_reg <= 1'b1;
          state_reg      <= ST_COLLECT;
        end else if (push) begin
          pend_valid_reg <= 1'b0;
        end
      end

      if (accept) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (accept && !pop)      count_reg <= count_reg + (PTR_W + 1)'(1);
      else if (pop && !accept) count_reg <= count_reg - (PTR_W + 1)'(1);

      if (drop && (drop_cnt_reg != 8'hFF))                 drop_cnt_reg <= drop_cnt_reg + 8'd1;
      if (accept && OVF_IN && (ovf_cnt_reg != 8'hFF))      ovf_cnt_reg  <= ovf_cnt_reg + 8'd1;
    end
  end

endmodule
